mmap_apb_bridge: RTL and testbench

MMAP_APB_BRIDGE -- requirements
Module: mmap_apb_bridge

---
 rtl/mmap_apb_bridge.sv | 124 ++++++++++++
 tb/tb_mmap_apb_bridge.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mmap_apb_bridge.sv
// Memory-mapped to APB bridge: decodes a 32 KB window into eight 4 KB APB slaves
// and runs one APB transfer at a time with an access-phase timeout.
module mmap_apb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         mmap_valid_i,
  input  logic [31:0]  mmap_addr_i,
  input  logic [31:0]  mmap_wdata_i,
  input  logic [3:0]   mmap_wstrb_i,
  output logic [31:0]  mmap_rdata_o,
  output logic         mmap_ready_o,
  output logic [11:0]  apb_paddr_o,
  output logic [31:0]  apb_pwdata_o,
  output logic         apb_pwrite_o,
  output logic [3:0]   apb_pstrb_o,
  output logic [7:0]   apb_psel_o,
  output logic         apb_penable_o,
  input  logic [255:0] apb_prdata_i,
  input  logic [7:0]   apb_pready_i,
  input  logic [7:0]   apb_pslverr_i,
  output logic         err_o,
  output logic [31:0]  err_addr_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  slot_q;
  logic [7:0]  cnt;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        hit;
  logic        sel_ready;
  logic        sel_err;
  logic [31:0] sel_rdata;

  assign hit       = (mmap_addr_i[31:15] == BASE_ADDR[31:15]);
  assign sel_ready = apb_pready_i[slot_q];
  assign sel_err   = apb_pslverr_i[slot_q];
  assign sel_rdata = apb_prdata_i[{slot_q, 5'b0} +: 32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      slot_q     <= '0;
      cnt        <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      err_addr_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mmap_valid_i) begin
            addr_q  <= mmap_addr_i;
            wdata_q <= mmap_wdata_i;
            wstrb_q <= mmap_wstrb_i;
            slot_q  <= mmap_addr_i[14:12];
            cnt     <= '0;
            rdata_q <= '0;
            if (hit) begin
              err_q <= 1'b0;
              state <= SETUP;
            end else begin
              // Decode misses never touch the APB side.
              err_q      <= 1'b1;
              err_addr_o <= mmap_addr_i;
              state      <= RESP;
            end
          end
        end
        SETUP: begin
          cnt   <= '0;
          state <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready) begin
            err_q   <= sel_err;
            rdata_q <= (sel_err || (|wstrb_q)) ? 32'h0 : sel_rdata;
            if (sel_err) err_addr_o <= addr_q;
            state <= RESP;
          end else if (cnt == LAST_CNT) begin
            err_q      <= 1'b1;
            rdata_q    <= '0;
            err_addr_o <= addr_q;
            state      <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // APB outputs come straight from the latched request so they stay stable
  // through the whole SETUP/ACCESS pair.
  assign mmap_ready_o  = (state == RESP);
  assign err_o         = (state == RESP) && err_q;
  assign mmap_rdata_o  = (state == RESP) ? rdata_q : 32'h0;
  assign apb_psel_o    = ((state == SETUP) || (state == ACCESS)) ? (8'b1 << slot_q) : 8'h00;
  assign apb_penable_o = (state == ACCESS);
  assign apb_paddr_o   = addr_q[11:0];
  assign apb_pwdata_o  = wdata_q;
  assign apb_pwrite_o  = |wstrb_q;
  assign apb_pstrb_o   = wstrb_q;

endmodule

// File: tb/tb_mmap_apb_bridge.sv
// Directed bench for mmap_apb_bridge; a second instance with TIMEOUT=3 covers
// the access-phase abort.
module tb_mmap_apb_bridge;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_a;
  logic         valid_b;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic [255:0] prdata;
  logic [7:0]   pready;
  logic [7:0]   pslverr;

  logic [31:0] rdata, t_rdata;
  logic        ready, t_ready;
  logic [11:0] paddr, t_paddr;
  logic [31:0] pwdata, t_pwdata;
  logic        pwrite, t_pwrite;
  logic [3:0]  pstrb, t_pstrb;
  logic [7:0]  psel, t_psel;
  logic        penable, t_penable;
  logic        err, t_err;
  logic [31:0] err_addr, t_err_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mmap_apb_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i), .mmap_valid_i(valid_a), .mmap_addr_i(addr),
    .mmap_wdata_i(wdata), .mmap_wstrb_i(wstrb), .mmap_rdata_o(rdata), .mmap_ready_o(ready),
    .apb_paddr_o(paddr), .apb_pwdata_o(pwdata), .apb_pwrite_o(pwrite), .apb_pstrb_o(pstrb),
    .apb_psel_o(psel), .apb_penable_o(penable), .apb_prdata_i(prdata), .apb_pready_i(pready),
    .apb_pslverr_i(pslverr), .err_o(err), .err_addr_o(err_addr)
  );

  mmap_apb_bridge #(.TIMEOUT(3)) dut_t (
    .clk_i(clk_i), .rst_i(rst_i), .mmap_valid_i(valid_b), .mmap_addr_i(addr),
    .mmap_wdata_i(wdata), .mmap_wstrb_i(wstrb), .mmap_rdata_o(t_rdata), .mmap_ready_o(t_ready),
    .apb_paddr_o(t_paddr), .apb_pwdata_o(t_pwdata), .apb_pwrite_o(t_pwrite), .apb_pstrb_o(t_pstrb),
    .apb_psel_o(t_psel), .apb_penable_o(t_penable), .apb_prdata_i(prdata), .apb_pready_i(pready),
    .apb_pslverr_i(pslverr), .err_o(t_err), .err_addr_o(t_err_addr)
  );

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
    addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
    pready = 8'h00; pslverr = 8'h00;
    next_cycle(); next_cycle();
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if (psel !== 8'h00) begin errors++; $display("[TB] FAIL reset_psel: got %h expected 00", psel); end
    checks++; if (penable !== 1'b0) begin errors++; $display("[TB] FAIL reset_penable: got %b expected 0", penable); end
    checks++; if (pwrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_pwrite: got %b expected 0", pwrite); end
    checks++; if (pstrb !== 4'h0) begin errors++; $display("[TB] FAIL reset_pstrb: got %h expected 0", pstrb); end
    checks++; if (paddr !== 12'h0) begin errors++; $display("[TB] FAIL reset_paddr: got %h expected 0", paddr); end
    checks++; if (pwdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_pwdata: got %h expected 0", pwdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_err_addr: got %h expected 0", err_addr); end
    rst_i = 1'b0;
  endtask

  task automatic test_read();
    pready = 8'hFF; pslverr = 8'h00;
    addr = 32'h0300_2010; wstrb = 4'h0; wdata = 32'hDEAD_BEEF; valid_a = 1'b1;
    next_cycle();
    checks++; if (psel !== 8'h04) begin errors++; $display("[TB] FAIL read_setup_psel: got %h expected 04", psel); end
    checks++; if (penable !== 1'b0) begin errors++; $display("[TB] FAIL read_setup_penable: got %b expected 0", penable); end
    checks++; if (paddr !== 12'h010) begin errors++; $display("[TB] FAIL read_paddr: got %h expected 010", paddr); end
    checks++; if (pwrite !== 1'b0) begin errors++; $display("[TB] FAIL read_pwrite: got %b expected 0", pwrite); end
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL read_c1_ready: got %b expected 0", ready); end
    next_cycle();
    checks++; if (penable !== 1'b1 || psel !== 8'h04) begin errors++; $display("[TB] FAIL read_access: got penable %b psel %h expected 1 04", penable, psel); end
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL read_c2_ready: got %b expected 0", ready); end
    next_cycle();
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL read_c3_ready: got %b expected 1", ready); end
    checks++; if (rdata !== 32'hA5A5_1234) begin errors++; $display("[TB] FAIL read_rdata: got %h expected a5a51234", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL read_err: got %b expected 0", err); end
    checks++; if (psel !== 8'h00 || penable !== 1'b0) begin errors++; $display("[TB] FAIL read_resp_apb: got psel %h penable %b expected 00 0", psel, penable); end
    valid_a = 1'b0;
    next_cycle();
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL read_ready_pulse: got %b expected 0", ready); end
  endtask

  task automatic test_write();
    // Other slots report ready+error; only slot 7 may matter.
    pready = 8'h7F; pslverr = 8'h7F;
    addr = 32'h0300_7FFC; wdata = 32'h1122_3344; wstrb = 4'b0011; valid_a = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      if (c == 2) valid_a = 1'b0;
      if (c == 5) pready = 8'hFF;
      if (c == 1) begin
        checks++; if (psel !== 8'h80 || penable !== 1'b0) begin errors++; $display("[TB] FAIL write_setup: got psel %h penable %b expected 80 0", psel, penable); end
        checks++; if (pwrite !== 1'b1 || pstrb !== 4'b0011) begin errors++; $display("[TB] FAIL write_ctrl: got pwrite %b pstrb %b expected 1 0011", pwrite, pstrb); end
        checks++; if (paddr !== 12'hFFC || pwdata !== 32'h1122_3344) begin errors++; $display("[TB] FAIL write_addr_data: got %h %h expected ffc 11223344", paddr, pwdata); end
      end else if (c <= 5) begin
        checks++; if (penable !== 1'b1 || psel !== 8'h80 || ready !== 1'b0) begin errors++; $display("[TB] FAIL write_access_c%0d: got penable %b psel %h ready %b expected 1 80 0", c, penable, psel, ready); end
        checks++; if (pwrite !== 1'b1 || pstrb !== 4'b0011 || paddr !== 12'hFFC) begin errors++; $display("[TB] FAIL write_stable_c%0d: got %b %b %h expected 1 0011 ffc", c, pwrite, pstrb, paddr); end
      end else begin
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL write_ready: got %b expected 1", ready); end
        checks++; if (rdata !== 32'h0 || err !== 1'b0) begin errors++; $display("[TB] FAIL write_resp: got rdata %h err %b expected 0 0", rdata, err); end
      end
    end
    pready = 8'h00; pslverr = 8'h00; wstrb = 4'h0;
    next_cycle();
  endtask

  task automatic test_miss();
    addr = 32'h0400_0000; wstrb = 4'h0; valid_a = 1'b1;
    next_cycle();
    checks++; if (ready !== 1'b1 || err !== 1'b1) begin errors++; $display("[TB] FAIL miss_resp: got ready %b err %b expected 1 1", ready, err); end
    checks++; if (psel !== 8'h00) begin errors++; $display("[TB] FAIL miss_psel: got %h expected 00", psel); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL miss_rdata: got %h expected 0", rdata); end
    checks++; if (err_addr !== 32'h0400_0000) begin errors++; $display("[TB] FAIL miss_err_addr: got %h expected 04000000", err_addr); end
    valid_a = 1'b0;
    next_cycle();
    checks++; if (err !== 1'b0 || err_addr !== 32'h0400_0000) begin errors++; $display("[TB] FAIL miss_hold: got err %b err_addr %h expected 0 04000000", err, err_addr); end
  endtask

  task automatic test_timeout();
    int access_cycles;
    access_cycles = 0;
    pready = 8'hFD; pslverr = 8'h00;
    addr = 32'h0300_1004; wstrb = 4'h0; valid_b = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      if (t_penable === 1'b1) access_cycles++;
      if (c == 1) begin
        checks++; if (t_psel !== 8'h02) begin errors++; $display("[TB] FAIL timeout_psel: got %h expected 02", t_psel); end
      end else if (c <= 4) begin
        checks++; if (t_ready !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early_ready_c%0d: got %b expected 0", c, t_ready); end
      end
    end
    checks++; if (access_cycles !== 3) begin errors++; $display("[TB] FAIL timeout_access_cycles: got %0d expected 3", access_cycles); end
    checks++; if (t_ready !== 1'b1 || t_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_resp: got ready %b err %b expected 1 1", t_ready, t_err); end
    checks++; if (t_psel !== 8'h00 || t_penable !== 1'b0) begin errors++; $display("[TB] FAIL timeout_apb_drop: got psel %h penable %b expected 00 0", t_psel, t_penable); end
    checks++; if (t_err_addr !== 32'h0300_1004) begin errors++; $display("[TB] FAIL timeout_err_addr: got %h expected 03001004", t_err_addr); end
    checks++; if (t_rdata !== 32'h0) begin errors++; $display("[TB] FAIL timeout_rdata: got %h expected 0", t_rdata); end
    valid_b = 1'b0; pready = 8'h00;
    next_cycle();
  endtask

  task automatic test_slverr();
    pready = 8'hFF; pslverr = 8'h20;
    addr = 32'h0300_5000; wstrb = 4'h0; valid_a = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    checks++; if (ready !== 1'b1 || err !== 1'b1) begin errors++; $display("[TB] FAIL slverr_resp: got ready %b err %b expected 1 1", ready, err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL slverr_rdata: got %h expected 0", rdata); end
    checks++; if (err_addr !== 32'h0300_5000) begin errors++; $display("[TB] FAIL slverr_err_addr: got %h expected 03005000", err_addr); end
    valid_a = 1'b0;
    next_cycle();
    addr = 32'h0300_0008; valid_a = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    checks++; if (ready !== 1'b1 || err !== 1'b0) begin errors++; $display("[TB] FAIL slot0_resp: got ready %b err %b expected 1 0", ready, err); end
    checks++; if (rdata !== 32'hC0DE_0000) begin errors++; $display("[TB] FAIL slot0_rdata: got %h expected c0de0000", rdata); end
    checks++; if (err_addr !== 32'h0300_5000) begin errors++; $display("[TB] FAIL slot0_err_addr_hold: got %h expected 03005000", err_addr); end
    valid_a = 1'b0; pslverr = 8'h00;
    next_cycle();
  endtask

  task automatic test_reset_mid_access();
    pready = 8'h00;
    addr = 32'h0300_3000; wstrb = 4'h0; valid_a = 1'b1;
    next_cycle(); next_cycle();
    checks++; if (penable !== 1'b1 || psel !== 8'h08) begin errors++; $display("[TB] FAIL rst_mid_access: got penable %b psel %h expected 1 08", penable, psel); end
    rst_i = 1'b1; valid_a = 1'b0;
    next_cycle();
    rst_i = 1'b0;
    checks++; if (psel !== 8'h00 || penable !== 1'b0 || ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_outputs: got psel %h penable %b ready %b expected 00 0 0", psel, penable, ready); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_err_addr: got %h expected 0", err_addr); end
    next_cycle();
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_no_ready: got %b expected 0", ready); end
    pready = 8'hFF;
    valid_a = 1'b1;
    next_cycle(); next_cycle();
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_new_early: got %b expected 0", ready); end
    next_cycle();
    checks++; if (ready !== 1'b1 || rdata !== 32'hC0DE_0003 || err !== 1'b0) begin errors++; $display("[TB] FAIL rst_new_resp: got ready %b rdata %h err %b expected 1 c0de0003 0", ready, rdata, err); end
    valid_a = 1'b0;
    next_cycle();
  endtask

  initial begin
    for (int n = 0; n < 8; n++) prdata[32*n +: 32] = 32'hC0DE_0000 + 32'(n);
    prdata[95:64] = 32'hA5A5_1234;
    test_reset();
    test_read();
    test_write();
    test_miss();
    test_timeout();
    test_slverr();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
